// File: rtl/decstage_pkg.sv
// Shared encodings for the decode stage: immediate-extension modes and
// instruction field positions.
package decstage_pkg;

  typedef enum logic [1:0] {
    IMM_SEXT     = 2'b00,
    IMM_ZEXT     = 2'b01,
    IMM_HI       = 2'b10,
    IMM_SEXT_SH2 = 2'b11
  } imm_sel_e;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RD_MSB  = 20;
  localparam int RD_LSB  = 16;
  localparam int RT_MSB  = 15;
  localparam int RT_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

endpackage

// File: rtl/regfile_2r1w.sv
// Register file: two asynchronous read ports, one synchronous write port.
// Register 0 and addresses at or beyond NREGS read as zero and ignore writes.
module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [4:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [4:0]        raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [4:0]        raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic [DATA_W-1:0] mem_q [NREGS];

  function automatic logic addr_live(input logic [4:0] addr);
    return (addr != 5'd0) && ({1'b0, addr} < 6'(NREGS));
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && addr_live(waddr_i)) begin
      mem_q[waddr_i[AW-1:0]] <= wdata_i;
    end
  end

  assign rdata_a_o = addr_live(raddr_a_i) ? mem_q[raddr_a_i[AW-1:0]] : '0;
  assign rdata_b_o = addr_live(raddr_b_i) ? mem_q[raddr_b_i[AW-1:0]] : '0;

endmodule

// File: rtl/pipe_decstage.sv
// Decode stage: reads two operands, extends the immediate and holds the
// bundle behind a valid/ready handshake, with write bypass and stall refresh.
module pipe_decstage
  import decstage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [31:0]       Instr,
  input  logic              RF_Bsel,
  input  logic [1:0]        ImmExt_sel,
  input  logic              RF_WrEn,
  input  logic [4:0]        RF_WrAddr,
  input  logic              RF_WrData_sel,
  input  logic [DATA_W-1:0] ALU_out,
  input  logic [DATA_W-1:0] MEM_out,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic [DATA_W-1:0] Immed,
  output logic [DATA_W-1:0] RF_A,
  output logic [DATA_W-1:0] RF_B,
  output logic [4:0]        Dst_addr
);

  logic [4:0]  rs, rd, rt, bsrc;
  logic [15:0] imm16;
  logic [5:0]  unused_opcode;

  assign rs            = Instr[RS_MSB:RS_LSB];
  assign rd            = Instr[RD_MSB:RD_LSB];
  assign rt            = Instr[RT_MSB:RT_LSB];
  assign imm16         = Instr[IMM_MSB:IMM_LSB];
  assign unused_opcode = Instr[OPC_MSB:OPC_LSB];
  assign bsrc          = RF_Bsel ? rd : rt;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] immed_q, immed_d;
  logic [DATA_W-1:0] rf_a_q, rf_a_d;
  logic [DATA_W-1:0] rf_b_q, rf_b_d;
  logic [4:0]        dst_q, dst_d;
  logic [4:0]        rs_q, rs_d;
  logic [4:0]        bsrc_q, bsrc_d;

  logic [DATA_W-1:0] rdata_a, rdata_b, wr_data, imm_ext;
  logic              wr_live, accept, stalled;

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_rf (
    .clk_i     (Clk),
    .rst_i     (Rst),
    .we_i      (RF_WrEn),
    .waddr_i   (RF_WrAddr),
    .wdata_i   (wr_data),
    .raddr_a_i (rs),
    .rdata_a_o (rdata_a),
    .raddr_b_i (bsrc),
    .rdata_b_o (rdata_b)
  );

  assign wr_data  = RF_WrData_sel ? MEM_out : ALU_out;
  assign wr_live  = RF_WrEn && (RF_WrAddr != 5'd0) && ({1'b0, RF_WrAddr} < 6'(NREGS));
  assign In_ready = !valid_q || Out_ready;
  assign accept   = In_valid && In_ready;
  assign stalled  = valid_q && !Out_ready;

  always_comb begin
    imm_ext = DATA_W'($signed(imm16));
    case (imm_sel_e'(ImmExt_sel))
      IMM_SEXT:     imm_ext = DATA_W'($signed(imm16));
      IMM_ZEXT:     imm_ext = DATA_W'(imm16);
      IMM_HI:       imm_ext = DATA_W'($signed({imm16, 16'h0000}));
      IMM_SEXT_SH2: imm_ext = DATA_W'($signed(imm16)) << 2;
      default:      imm_ext = DATA_W'($signed(imm16));
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    immed_d = immed_q;
    rf_a_d  = rf_a_q;
    rf_b_d  = rf_b_q;
    dst_d   = dst_q;
    rs_d    = rs_q;
    bsrc_d  = bsrc_q;
    if (accept) begin
      // Same-cycle writeback wins over the stale storage entry.
      valid_d = 1'b1;
      immed_d = imm_ext;
      dst_d   = rd;
      rs_d    = rs;
      bsrc_d  = bsrc;
      rf_a_d  = (wr_live && (RF_WrAddr == rs))   ? wr_data : rdata_a;
      rf_b_d  = (wr_live && (RF_WrAddr == bsrc)) ? wr_data : rdata_b;
    end else if (stalled) begin
      if (wr_live && (RF_WrAddr == rs_q))   rf_a_d = wr_data;
      if (wr_live && (RF_WrAddr == bsrc_q)) rf_b_d = wr_data;
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      valid_q <= 1'b0;
      immed_q <= '0;
      rf_a_q  <= '0;
      rf_b_q  <= '0;
      dst_q   <= '0;
      rs_q    <= '0;
      bsrc_q  <= '0;
    end else begin
      valid_q <= valid_d;
      immed_q <= immed_d;
      rf_a_q  <= rf_a_d;
      rf_b_q  <= rf_b_d;
      dst_q   <= dst_d;
      rs_q    <= rs_d;
      bsrc_q  <= bsrc_d;
    end
  end

  assign Out_valid = valid_q;
  assign Immed     = immed_q;
  assign RF_A      = rf_a_q;
  assign RF_B      = rf_b_q;
  assign Dst_addr  = dst_q;

endmodule

// File: tb/tb_pipe_decstage.sv
// Bench for pipe_decstage: directed scenarios plus random traffic, all checked
// against a register-array model of the stage.
module tb_pipe_decstage;

  localparam int DW = 32;
  localparam int NR = 16;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          In_valid;
  logic          In_ready;
  logic [31:0]   Instr;
  logic          RF_Bsel;
  logic [1:0]    ImmExt_sel;
  logic          RF_WrEn;
  logic [4:0]    RF_WrAddr;
  logic          RF_WrData_sel;
  logic [DW-1:0] ALU_out;
  logic [DW-1:0] MEM_out;
  logic          Out_valid;
  logic          Out_ready;
  logic [DW-1:0] Immed;
  logic [DW-1:0] RF_A;
  logic [DW-1:0] RF_B;
  logic [4:0]    Dst_addr;

  pipe_decstage #(.DATA_W(DW), .NREGS(NR)) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .In_valid      (In_valid),
    .In_ready      (In_ready),
    .Instr         (Instr),
    .RF_Bsel       (RF_Bsel),
    .ImmExt_sel    (ImmExt_sel),
    .RF_WrEn       (RF_WrEn),
    .RF_WrAddr     (RF_WrAddr),
    .RF_WrData_sel (RF_WrData_sel),
    .ALU_out       (ALU_out),
    .MEM_out       (MEM_out),
    .Out_valid     (Out_valid),
    .Out_ready     (Out_ready),
    .Immed         (Immed),
    .RF_A          (RF_A),
    .RF_B          (RF_B),
    .Dst_addr      (Dst_addr)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Model: architectural register contents and the bundle the stage should show.
  logic [DW-1:0] m_rf [32];
  bit            m_valid;
  logic [DW-1:0] m_imm, m_a, m_b;
  logic [4:0]    m_dst, m_rs, m_bsrc;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] m_read(input logic [4:0] a);
    if (a == 0 || int'(a) >= NR) return '0;
    return m_rf[a];
  endfunction

  function automatic logic [DW-1:0] imm_model(input logic [1:0] sel, input logic [15:0] imm);
    longint s;
    s = longint'(imm);
    if (imm >= 16'h8000) s = s - 65536;
    case (sel)
      2'd0:    return DW'(s);
      2'd1:    return DW'(longint'(imm));
      2'd2:    return DW'(s * 65536);
      default: return DW'(s * 4);
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rd, input logic [15:0] imm);
    return {6'h00, rs, rd, imm};
  endfunction

  task automatic drive_idle();
    Rst = 0; In_valid = 0; Instr = '0; RF_Bsel = 0; ImmExt_sel = 2'd0;
    RF_WrEn = 0; RF_WrAddr = '0; RF_WrData_sel = 0; ALU_out = '0; MEM_out = '0;
    Out_ready = 1;
  endtask

  // Apply the current inputs across one rising edge and compare against the model.
  task automatic step();
    bit exp_ready, rst_now;
    logic [4:0] f_rs, f_rd, f_rt;
    #1;
    exp_ready = !m_valid || Out_ready;
    if (!Rst) check_eq("in_ready", In_ready, exp_ready);
    rst_now = Rst;
    if (Rst) begin
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_valid = 0; m_imm = '0; m_a = '0; m_b = '0; m_dst = '0; m_rs = '0; m_bsrc = '0;
    end else begin
      if (RF_WrEn && RF_WrAddr != 0 && int'(RF_WrAddr) < NR)
        m_rf[RF_WrAddr] = RF_WrData_sel ? MEM_out : ALU_out;
      f_rs = Instr[25:21];
      f_rd = Instr[20:16];
      f_rt = Instr[15:11];
      if (In_valid && exp_ready) begin
        m_valid = 1;
        m_imm   = imm_model(ImmExt_sel, Instr[15:0]);
        m_dst   = f_rd;
        m_rs    = f_rs;
        m_bsrc  = RF_Bsel ? f_rd : f_rt;
        m_a     = m_read(m_rs);
        m_b     = m_read(m_bsrc);
      end else if (m_valid && !Out_ready) begin
        m_a = m_read(m_rs);
        m_b = m_read(m_bsrc);
      end else begin
        m_valid = 0;
      end
    end
    @(posedge Clk);
    #1;
    check_eq("out_valid", Out_valid, m_valid);
    if (m_valid || rst_now) begin
      check_eq("immed", Immed, m_imm);
      check_eq("rf_a", RF_A, m_a);
      check_eq("rf_b", RF_B, m_b);
      check_eq("dst_addr", Dst_addr, m_dst);
    end
  endtask

  logic [4:0] pool [8];

  initial begin
    pool[0] = 5'd0;  pool[1] = 5'd1;  pool[2] = 5'd2;  pool[3] = 5'd4;
    pool[4] = 5'd7;  pool[5] = 5'd15; pool[6] = 5'd16; pool[7] = 5'd31;
    m_valid = 0;
    for (int i = 0; i < 32; i++) m_rf[i] = '0;

    drive_idle();
    Rst = 1;
    step();
    step();
    drive_idle();
    #1 check_eq("ready_after_rst", In_ready, 1);

    // Fill registers, confirm contents, then reset clears them.
    for (int i = 1; i < 32; i++) begin
      drive_idle(); RF_WrEn = 1; RF_WrAddr = 5'(i); ALU_out = DW'(i);
      step();
    end
    drive_idle(); In_valid = 1; Instr = mk(5'd5, 5'd15, 16'h0000); RF_Bsel = 1;
    step();
    check_eq("pre_rst_r5", RF_A, 32'd5);
    check_eq("pre_rst_r15", RF_B, 32'd15);
    drive_idle(); Rst = 1;
    step();
    check_eq("rst_valid", Out_valid, 0);
    drive_idle(); In_valid = 1; Instr = mk(5'd5, 5'd31, 16'h0000); RF_Bsel = 1;
    step();
    check_eq("rst_r5", RF_A, 32'd0);
    check_eq("rst_r31", RF_B, 32'd0);

    // Basic read with sign-extended immediate.
    drive_idle(); RF_WrEn = 1; RF_WrAddr = 5'd4; ALU_out = 32'h11; step();
    drive_idle(); RF_WrEn = 1; RF_WrAddr = 5'd9; ALU_out = 32'h22; step();
    drive_idle(); In_valid = 1; Instr = mk(5'd4, 5'd9, 16'h8004); RF_Bsel = 1; ImmExt_sel = 2'd0;
    step();
    check_eq("read_valid", Out_valid, 1);
    check_eq("read_a", RF_A, 32'h11);
    check_eq("read_b", RF_B, 32'h22);
    check_eq("read_imm", Immed, 32'hFFFF8004);
    check_eq("read_dst", Dst_addr, 5'd9);

    // Remaining immediate modes.
    drive_idle(); In_valid = 1; Instr = mk(5'd4, 5'd9, 16'h8004); ImmExt_sel = 2'd1; step();
    check_eq("imm_zext", Immed, 32'h00008004);
    ImmExt_sel = 2'd2; step();
    check_eq("imm_hi", Immed, 32'h80040000);
    ImmExt_sel = 2'd3; step();
    check_eq("imm_sh2", Immed, 32'hFFFE0010);

    // Bypass from MEM_out, and r0 stays zero even when written.
    drive_idle(); In_valid = 1; Instr = mk(5'd7, 5'd7, 16'h0000); RF_Bsel = 1;
    RF_WrEn = 1; RF_WrAddr = 5'd7; RF_WrData_sel = 1; MEM_out = 32'hABCD; ALU_out = 32'h1111;
    step();
    check_eq("bypass_a", RF_A, 32'hABCD);
    check_eq("bypass_b", RF_B, 32'hABCD);
    drive_idle(); In_valid = 1; Instr = mk(5'd0, 5'd0, 16'h0000);
    RF_WrEn = 1; RF_WrAddr = 5'd0; ALU_out = 32'h1234;
    step();
    check_eq("bypass_r0", RF_A, 32'd0);

    // Stall with refresh, then release accepts the waiting instruction.
    drive_idle(); In_valid = 1; Instr = mk(5'd4, 5'd3, 16'h1234); step();
    Out_ready = 0; Instr = mk(5'd9, 5'd2, 16'h00F0);
    for (int k = 0; k < 3; k++) begin
      RF_WrEn = (k == 1); RF_WrAddr = 5'd4; ALU_out = 32'h55;
      #1 check_eq("stall_ready", In_ready, 0);
      step();
      check_eq("stall_imm", Immed, 32'h1234);
      check_eq("stall_dst", Dst_addr, 5'd3);
      if (k >= 1) check_eq("stall_refresh", RF_A, 32'h55);
    end
    RF_WrEn = 0; Out_ready = 1;
    #1 check_eq("release_ready", In_ready, 1);
    step();
    check_eq("release_imm", Immed, 32'h00F0);
    check_eq("release_dst", Dst_addr, 5'd2);

    // Reset while stalled discards the bundle.
    drive_idle(); In_valid = 1; Instr = mk(5'd9, 5'd4, 16'h7777); step();
    Out_ready = 0; step();
    Rst = 1; step();
    check_eq("rst_stall_valid", Out_valid, 0);
    check_eq("rst_stall_imm", Immed, 32'd0);
    check_eq("rst_stall_a", RF_A, 32'd0);
    check_eq("rst_stall_b", RF_B, 32'd0);
    check_eq("rst_stall_dst", Dst_addr, 5'd0);
    drive_idle(); step();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      Rst           = ($urandom_range(0, 63) == 0);
      In_valid      = $urandom_range(0, 1);
      Out_ready     = ($urandom_range(0, 9) < 7);
      Instr         = {6'($urandom), pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)],
                       pool[$urandom_range(0, 7)], 11'($urandom)};
      RF_Bsel       = $urandom_range(0, 1);
      ImmExt_sel    = 2'($urandom);
      RF_WrEn       = $urandom_range(0, 1);
      RF_WrAddr     = pool[$urandom_range(0, 7)];
      RF_WrData_sel = $urandom_range(0, 1);
      ALU_out       = $urandom;
      MEM_out       = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
